// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage.
// Owns HI/LO and raises busy while a mult/div is in flight.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;
  logic          pwr_q, pwr_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic [63:0] smul;
  logic [63:0] umul;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;

  assign accept = start & ~flush & ~busy_q;
  assign is_mul = (op == OP_MULT) | (op == OP_MULTU);
  assign is_div = (op == OP_DIV) | (op == OP_DIVU);

  assign smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign umul = {32'b0, a} * {32'b0, b};

  // Signed divide on magnitudes; 0x80000000/-1 wraps back to 0x80000000.
  assign a_neg = (op == OP_DIV) & a[31];
  assign b_neg = (op == OP_DIV) & b[31];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign uq    = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign ur    = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign q     = (a_neg ^ b_neg) ? -uq : uq;
  assign r     = a_neg ? -ur : ur;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    pwr_d  = pwr_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (accept) begin
      unique case (1'b1)
        is_mul: begin
          pend_d = (op == OP_MULT) ? smul : umul;
          pwr_d  = 1'b1;
          cnt_d  = CW'(MULT_CYCLES - 1);
          busy_d = 1'b1;
        end
        is_div: begin
          pend_d = {r, q};
          pwr_d  = (b != 32'd0);
          cnt_d  = CW'(DIV_CYCLES - 1);
          busy_d = 1'b1;
        end
        (op == OP_MTHI): hi_d = a;
        (op == OP_MTLO): lo_d = a;
        default: ;
      endcase
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        if (pwr_q) begin
          hi_d = pend_q[63:32];
          lo_d = pend_q[31:0];
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      pend_q <= '0;
      pwr_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      pwr_q  <= pwr_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops
// against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec;
  int n_bad;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: update model HI/LO, return expected busy length.
  function automatic int model(input logic [2:0] o,
                               input logic [31:0] x,
                               input logic [31:0] y,
                               input logic fl);
    longint sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up;
    if (fl) return 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'd1: begin
        sp = sx * sy;
        {m_hi, m_lo} = sp;
        return MC;
      end
      3'd2: begin
        up = ux * uy;
        {m_hi, m_lo} = up;
        return MC;
      end
      3'd3: begin
        if (y != 0) begin
          sq = sx / sy;
          sr = sx % sy;
          m_lo = sq[31:0];
          m_hi = sr[31:0];
        end
        return DC;
      end
      3'd4: begin
        if (y != 0) begin
          m_lo = 32'(ux / uy);
          m_hi = 32'(ux % uy);
        end
        return DC;
      end
      3'd5: begin m_hi = x; return 0; end
      3'd6: begin m_lo = x; return 0; end
      default: return 0;
    endcase
  endfunction

  task automatic run_op(input string tag,
                        input logic [2:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic fl);
    int nb;
    int exp_n;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    flush = fl;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    exp_n = model(o, x, y, fl);
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    chk({tag, ".busy"}, 64'(nb), 64'(exp_n));
    chk({tag, ".hi"}, {32'b0, hi}, {32'b0, m_hi});
    chk({tag, ".lo"}, {32'b0, lo}, {32'b0, m_lo});
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    m_hi    = '0;
    m_lo    = '0;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = '0;
    a       = '0;
    b       = '0;
    flush   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", {63'b0, busy}, 64'd0);
    chk("rst.hi", {32'b0, hi}, 64'd0);
    chk("rst.lo", {32'b0, lo}, 64'd0);
    reset_n = 1'b1;

    run_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    chk("mult_neg.hi_lit", {32'b0, hi}, 64'hFFFFFFFF);
    chk("mult_neg.lo_lit", {32'b0, lo}, 64'hFFFFFFF1);
    run_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("multu_max.lit", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op("mult_m1", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("mult_m1.lit", {hi, lo}, 64'h00000000_00000001);
    run_op("div_m7", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_m7.lit", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu_m7", 3'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("divu_m7.lit", {hi, lo}, 64'h00000001_7FFFFFFC);
    run_op("mthi_aa", 3'd5, 32'hAA, 32'd0, 1'b0);
    run_op("mtlo_bb", 3'd6, 32'hBB, 32'd0, 1'b0);
    run_op("divu_z", 3'd4, 32'h1234, 32'd0, 1'b0);
    chk("divu_z.lit", {hi, lo}, 64'h000000AA_000000BB);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("div_ovf.lit", {hi, lo}, 64'h00000000_80000000);
    run_op("flush_mult", 3'd1, 32'd7, 32'd9, 1'b1);
    run_op("mthi_55", 3'd5, 32'h55, 32'd0, 1'b0);
    chk("mthi_55.lit", {32'b0, hi}, 64'h55);
    run_op("unk0", 3'd0, 32'd3, 32'd4, 1'b0);
    run_op("unk7", 3'd7, 32'd3, 32'd4, 1'b0);

    // Flush arriving while busy must not abort the in-flight op.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd1000; flush = 1'b0;
    @(negedge clk);
    start = 1'b0;
    void'(model(3'd2, 32'd1000, 32'd1000, 1'b0));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (MC + 2) @(negedge clk);
    chk("flush_busy.busy", {63'b0, busy}, 64'd0);
    chk("flush_busy.lo", {32'b0, lo}, {32'b0, m_lo});

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rf;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 16));
      if ($urandom_range(0, 3) == 0) rb = -rb;
      rf = ($urandom_range(0, 7) == 0);
      run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, rf);
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid.busy_pre", {63'b0, busy}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid.busy", {63'b0, busy}, 64'd0);
    chk("rst_mid.hilo", {hi, lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    run_op("post_rst", 3'd1, 32'd2, 32'd3, 1'b0);
    chk("post_rst.lo_lit", {32'b0, lo}, 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
